// File: rtl/shift_pkg.sv
// Shared op encodings, FSM states and op classification for the shift-register unit.
// SHIFT_ROTATE_EN makes ROL/ROR legal shift ops; without it they are treated as illegal.
package shift_pkg;

  typedef enum logic [2:0] {
    OpLoad = 3'b000,
    OpSll  = 3'b001,
    OpSrl  = 3'b010,
    OpSra  = 3'b011,
    OpRol  = 3'b100,
    OpRor  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  function automatic logic op_is_shift(input logic [2:0] op);
    logic res;
    res = 1'b0;
    case (op)
      OpSll, OpSrl, OpSra: res = 1'b1;
`ifdef SHIFT_ROTATE_EN
      OpRol, OpRor:        res = 1'b1;
`endif
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OpLoad) || op_is_shift(op);
  endfunction

endpackage

// File: rtl/mux_param_n.sv
// Combinational N:1 selector over a packed source bus; out-of-range select gives 0 and invalid=1.
module mux_param_n #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_in,
  output logic [WIDTH-1:0]         out,
  output logic                     invalid
);

  always_comb begin
    out     = '0;
    invalid = 1'b1;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        out     = src_in[k*WIDTH +: WIDTH];
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_reg_mux_unit.sv
// Source-selecting iterative shift register: latch one of NUM_SRC operands, shift 1 bit/cycle.
// Define SHIFT_ROTATE_EN to enable ROL/ROR; otherwise those encodings load only and flag err.
module shift_reg_mux_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [$clog2(NUM_SRC)-1:0] src_sel,
  input  logic [NUM_SRC*WIDTH-1:0]   src_in,
  input  logic [SHAMT_W-1:0]         shamt,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       err
);

  localparam int unsigned SelW = $clog2(NUM_SRC);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [2:0]         op_q, op_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   sel_val;
  logic               sel_invalid;
  logic [WIDTH-1:0]   shift_val;

  mux_param_n #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SelW)
  ) u_mux (
    .sel     (src_sel),
    .src_in  (src_in),
    .out     (sel_val),
    .invalid (sel_invalid)
  );

  // SRA keeps acc MSB each step, so the sign latched at accept persists.
  always_comb begin
    shift_val = acc_q;
    case (op_q)
      OpSll:   shift_val = {acc_q[WIDTH-2:0], 1'b0};
      OpSrl:   shift_val = {1'b0, acc_q[WIDTH-1:1]};
      OpSra:   shift_val = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      OpRol:   shift_val = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
      OpRor:   shift_val = {acc_q[0], acc_q[WIDTH-1:1]};
`endif
      default: shift_val = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = sel_val;
          op_d    = op;
          count_d = shamt;
          err_d   = sel_invalid | ~op_is_legal(op);
          state_d = (op_is_shift(op) && (shamt != '0)) ? StShift : StDone;
        end
      end
      StShift: begin
        acc_d   = shift_val;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      op_q    <= OpLoad;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = acc_q;
  assign err    = err_q;

endmodule

// File: tb/tb_shift_reg_mux_unit.sv
// Randomized self-checking bench for shift_reg_mux_unit against an arithmetic reference model.
module tb_shift_reg_mux_unit;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned SHAMT_W = 5;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic [2:0]               op;
  logic [1:0]               src_sel;
  logic [NUM_SRC*WIDTH-1:0] src_in;
  logic [SHAMT_W-1:0]       shamt;
  logic                     busy;
  logic                     done;
  logic [WIDTH-1:0]         result;
  logic                     err;

  int n_cmp;
  int n_mis;

  shift_reg_mux_unit #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SHAMT_W (SHAMT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_sel (src_sel),
    .src_in  (src_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-operation reference: final value as one arithmetic shift/rotate by shamt.
  function automatic void model(input logic [1:0] sel, input logic [2:0] o, input int sh,
                                input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, output logic [31:0] r,
                                output logic e, output int lat);
    logic [31:0] v;
    logic        is_shift;
    int          rot;
    v = (sel == 0) ? s0 : (sel == 1) ? s1 : (sel == 2) ? s2 : 32'h0;
    e = (sel >= NUM_SRC);
    is_shift = 1'b1;
    rot = sh % 32;
    r = v;
    case (o)
      3'b000: is_shift = 1'b0;
      3'b001: r = v << sh;
      3'b010: r = v >> sh;
      3'b011: r = $unsigned($signed(v) >>> sh);
`ifdef SHIFT_ROTATE_EN
      3'b100: r = (rot == 0) ? v : ((v << rot) | (v >> (32 - rot)));
      3'b101: r = (rot == 0) ? v : ((v >> rot) | (v << (32 - rot)));
`endif
      default: begin
        is_shift = 1'b0;
        e = 1'b1;
      end
    endcase
    lat = (is_shift && sh != 0) ? sh : 0;
  endfunction

  task automatic drive_junk();
    start   = 1'($urandom_range(0, 1));
    op      = 3'($urandom);
    src_sel = 2'($urandom);
    shamt   = 5'($urandom);
    src_in  = {$urandom, $urandom, $urandom};
  endtask

  task automatic run_op(input string tag, input logic [1:0] sel, input logic [2:0] o,
                        input logic [4:0] sh, input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] s2);
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_lat;
    int          lat;
    bit          seen;
    model(sel, o, int'(sh), s0, s1, s2, exp_res, exp_err, exp_lat);
    @(negedge clk);
    src_in  = {s2, s1, s0};
    src_sel = sel;
    op      = o;
    shamt   = sh;
    start   = 1'b1;
    @(posedge clk);
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive_junk();
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check_val({tag, "_result"}, 64'(result), 64'(exp_res));
      check_val({tag, "_err"}, 64'(err), 64'(exp_err));
      check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_val({tag, "_busy_at_done"}, 64'(busy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
      check_val({tag, "_idle_done"}, 64'(done), 64'd0);
      check_val({tag, "_hold_result"}, 64'(result), 64'(exp_res));
      check_val({tag, "_hold_err"}, 64'(err), 64'(exp_err));
    end else begin
      start = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] s0, s1, s2;
    n_cmp   = 0;
    n_mis   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 3'b000;
    src_sel = 2'd0;
    src_in  = '0;
    shamt   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_result", 64'(result), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);

    // Reset held two cycles in the middle of a long SRL.
    src_in  = {32'h0, 32'h0, 32'hA5A5_0F0F};
    src_sel = 2'd0;
    op      = 3'b010;
    shamt   = 5'd20;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_done", 64'(done), 64'd0);
    check_val("midrst_result", 64'(result), 64'd0);
    check_val("midrst_err", 64'(err), 64'd0);
    reset = 1'b0;

    run_op("srl4", 2'd1, 3'b010, 5'd4, 32'h0, 32'h0000_00F0, 32'h0);
    run_op("sra31", 2'd2, 3'b011, 5'd31, 32'h0, 32'h0, 32'h8000_0000);
    run_op("sll0", 2'd0, 3'b001, 5'd0, 32'h1234_5678, 32'h1, 32'h2);
    run_op("badsel", 2'd3, 3'b000, 5'd7, 32'hDEAD_BEEF, 32'h1, 32'h2);
    run_op("clrerr", 2'd1, 3'b000, 5'd0, 32'h0, 32'hCAFE_F00D, 32'h0);
    run_op("rol1", 2'd0, 3'b100, 5'd1, 32'h8000_0001, 32'h0, 32'h0);
    run_op("ror3", 2'd0, 3'b101, 5'd3, 32'h0000_000B, 32'h0, 32'h0);
    run_op("badop", 2'd2, 3'b110, 5'd9, 32'h0, 32'h0, 32'h5555_AAAA);

    // err set above must be cleared by reset.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst2_err", 64'(err), 64'd0);
    check_val("rst2_result", 64'(result), 64'd0);

    for (int t = 0; t < 60; t++) begin
      s0 = $urandom;
      s1 = $urandom;
      s2 = $urandom;
      run_op($sformatf("rnd%0d", t), 2'($urandom), 3'($urandom),
             5'($urandom_range(0, 1) ? $urandom_range(0, 6) : $urandom_range(0, 31)),
             s0, s1, s2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
